// File: rtl/pifo_pkg.sv
// Shared types and widths for the PIFO push path: the staged push request
// and the rank/flow/counter widths used by the arbiter and scheduler.
package pifo_pkg;

  localparam int RANK_W = 32;
  localparam int FLOW_W = 10;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [RANK_W-1:0] rank;
    logic [RANK_W-1:0] value;
    logic [FLOW_W-1:0] flow;
  } push_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Rotating pick-two: scans occupancy starting at ptr and returns the first
// and (when en2) second occupied ports as one-hot grants.
module rr_pick2 #(
  parameter  int PORTS = 4,
  localparam int PW    = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] occ,
  input  logic [PW-1:0]    ptr,
  input  logic             en2,
  output logic [PORTS-1:0] gnt1,
  output logic [PORTS-1:0] gnt2,
  output logic             vld1,
  output logic             vld2
);

  logic [PW:0] pos;

  always_comb begin
    gnt1 = '0;
    gnt2 = '0;
    vld1 = 1'b0;
    vld2 = 1'b0;
    pos  = '0;
    for (int k = 0; k < PORTS; k++) begin
      // One extra bit so ptr + k cannot overflow before the modulo wrap.
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(PORTS)) pos = pos - (PW+1)'(PORTS);
      if (occ[pos[PW-1:0]]) begin
        if (!vld1) begin
          gnt1[pos[PW-1:0]] = 1'b1;
          vld1              = 1'b1;
        end else if (en2 && !vld2) begin
          gnt2[pos[PW-1:0]] = 1'b1;
          vld2              = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/push_arbiter.sv
// Per-port single-entry staging with round-robin arbitration onto the two
// scheduler push lanes; grants are combinational from staged occupancy.
module push_arbiter
  import pifo_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int FLOWS = FLOW_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             req_valid,
  input  logic [PORTS-1:0][RANK_W-1:0] req_rank,
  input  logic [PORTS-1:0][RANK_W-1:0] req_value,
  input  logic [PORTS-1:0][FLOWS-1:0]  req_flow,
  output logic [PORTS-1:0]             req_ready,
  input  logic                         can_push_1,
  input  logic                         can_push_2,
  output logic                         push_1,
  output logic [RANK_W-1:0]            push_rank_1,
  output logic [RANK_W-1:0]            push_value_1,
  output logic [FLOWS-1:0]             push_flow_1,
  output logic                         push_2,
  output logic [RANK_W-1:0]            push_rank_2,
  output logic [RANK_W-1:0]            push_value_2,
  output logic [FLOWS-1:0]             push_flow_2,
  output logic [PORTS-1:0][CNT_W-1:0]  grant_count
);

  localparam int PW = $clog2(PORTS);

  logic [PORTS-1:0]            buf_valid_q, buf_valid_d;
  push_req_t                   buf_q [PORTS];
  push_req_t                   buf_d [PORTS];
  logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [PORTS-1:0][CNT_W-1:0] grant_count_q, grant_count_d;

  logic [PORTS-1:0] gnt1, gnt2, grant, load;
  logic             vld1, vld2;
  logic [PW-1:0]    idx1, idx2;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(PORTS-1)) ? '0 : idx + 1'b1;
  endfunction

  // Masking occupancy with can_push_1 suppresses both lanes when the scheduler is full.
  rr_pick2 #(.PORTS(PORTS)) u_pick (
    .occ  (buf_valid_q & {PORTS{can_push_1}}),
    .ptr  (rr_ptr_q),
    .en2  (can_push_2),
    .gnt1 (gnt1),
    .gnt2 (gnt2),
    .vld1 (vld1),
    .vld2 (vld2)
  );

  always_comb begin
    grant       = gnt1 | gnt2;
    req_ready   = ~buf_valid_q | grant;
    load        = req_valid & req_ready;
    buf_valid_d = (buf_valid_q & ~grant) | load;
    idx1        = '0;
    idx2        = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (gnt1[p]) idx1 = PW'(p);
      if (gnt2[p]) idx2 = PW'(p);
    end
    rr_ptr_d = rr_ptr_q;
    if (vld2)      rr_ptr_d = next_ptr(idx2);
    else if (vld1) rr_ptr_d = next_ptr(idx1);
    for (int p = 0; p < PORTS; p++) begin
      grant_count_d[p] = grant_count_q[p] + {{(CNT_W-1){1'b0}}, grant[p]};
      buf_d[p]         = buf_q[p];
      if (load[p]) buf_d[p] = '{rank: req_rank[p], value: req_value[p], flow: req_flow[p]};
    end
  end

  // AND-OR lane muxes: entries that are not granted contribute zeros, never stale data.
  always_comb begin
    push_1       = vld1;
    push_2       = vld2;
    push_rank_1  = '0;
    push_value_1 = '0;
    push_flow_1  = '0;
    push_rank_2  = '0;
    push_value_2 = '0;
    push_flow_2  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (gnt1[p]) begin
        push_rank_1  = buf_q[p].rank;
        push_value_1 = buf_q[p].value;
        push_flow_1  = buf_q[p].flow;
      end
      if (gnt2[p]) begin
        push_rank_2  = buf_q[p].rank;
        push_value_2 = buf_q[p].value;
        push_flow_2  = buf_q[p].flow;
      end
    end
  end

  assign grant_count = grant_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q   <= '0;
      rr_ptr_q      <= '0;
      grant_count_q <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_count_q <= grant_count_d;
    end
  end

  // Staged payload is qualified by buf_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_push_arbiter.sv
// Directed bench for push_arbiter (PORTS=4): arbitration order, lane pairing,
// back-pressure, streaming latency, async reset and counter wrap.
module tb_push_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_rank;
  logic [3:0][31:0] req_value;
  logic [3:0][9:0]  req_flow;
  logic [3:0]       req_ready;
  logic             can_push_1, can_push_2;
  logic             push_1, push_2;
  logic [31:0]      push_rank_1, push_value_1, push_rank_2, push_value_2;
  logic [9:0]       push_flow_1, push_flow_2;
  logic [3:0][15:0] grant_count;

  int total = 0;
  int bad   = 0;

  push_arbiter #(.PORTS(4), .FLOWS(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rank     (req_rank),
    .req_value    (req_value),
    .req_flow     (req_flow),
    .req_ready    (req_ready),
    .can_push_1   (can_push_1),
    .can_push_2   (can_push_2),
    .push_1       (push_1),
    .push_rank_1  (push_rank_1),
    .push_value_1 (push_value_1),
    .push_flow_1  (push_flow_1),
    .push_2       (push_2),
    .push_rank_2  (push_rank_2),
    .push_value_2 (push_value_2),
    .push_flow_2  (push_flow_2),
    .grant_count  (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Port p carries rank base+p, value A000_0000+rank, flow = low 10 bits of rank.
  task automatic set_req(input logic [3:0] mask, input int base);
    for (int p = 0; p < 4; p++) begin
      req_rank[p]  = 32'(base + p);
      req_value[p] = 32'hA000_0000 + 32'(base + p);
      req_flow[p]  = 10'(base + p);
    end
    req_valid = mask;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; can_push_1 = 1'b0; can_push_2 = 1'b0;
    set_req(4'b0000, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_push1", push_1, 0);
    chk("rst_push2", push_2, 0);
    chk("rst_ready", req_ready, 4'hF);
    chk("rst_cnt", grant_count, 0);
    chk("rst_rank1", push_rank_1, 0);
    @(negedge clk); rst = 1'b1;

    // Ports 1 and 3 staged, both lanes available, pointer at 0.
    @(negedge clk); set_req(4'b1010, 10);
    #1; chk("b_ready_load", req_ready, 4'hF); chk("b_no_push", push_1, 0);
    @(negedge clk); req_valid = 4'b0000; can_push_1 = 1'b1; can_push_2 = 1'b1;
    #1;
    chk("b_push1", push_1, 1);
    chk("b_rank1", push_rank_1, 11);
    chk("b_value1", push_value_1, 32'hA000_000B);
    chk("b_flow1", push_flow_1, 11);
    chk("b_push2", push_2, 1);
    chk("b_rank2", push_rank_2, 13);
    chk("b_flow2", push_flow_2, 13);
    @(negedge clk); can_push_1 = 1'b0; can_push_2 = 1'b0;
    #1;
    chk("b_idle", push_1, 0);
    chk("b_idle_rank", push_rank_1, 0);
    chk("b_idle_value2", push_value_2, 0);
    chk("b_cnt", grant_count, 64'h0001_0000_0001_0000);

    // All four full, single lane: one per cycle starting at port 0.
    @(negedge clk); set_req(4'hF, 100);
    @(negedge clk); req_valid = 4'b0000; can_push_1 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("c_push1", push_1, 1);
      chk("c_rank1", push_rank_1, 64'(100 + i));
      chk("c_push2", push_2, 0);
      @(negedge clk); #1;
    end
    chk("c_done", push_1, 0);
    chk("c_cnt", grant_count, 64'h0002_0001_0002_0001);

    // Scheduler full: no grants, no ready, staged data must survive new offers.
    @(negedge clk); can_push_1 = 1'b0; set_req(4'hF, 200);
    #1; chk("d_ready_load", req_ready, 4'hF);
    @(negedge clk); set_req(4'hF, 300);
    #1; chk("d_ready_stall", req_ready, 4'h0); chk("d_no_push", push_1, 0);
    @(negedge clk);
    #1; chk("d_ready_hold", req_ready, 4'h0); chk("d_no_push2", push_2, 0);
    @(negedge clk); req_valid = 4'b0000; can_push_1 = 1'b1; can_push_2 = 1'b1;
    #1;
    chk("d_rank1", push_rank_1, 200);
    chk("d_rank2", push_rank_2, 201);
    chk("d_push2", push_2, 1);
    chk("d_ready_part", req_ready, 4'b0011);
    @(negedge clk);
    #1; chk("d_rank1b", push_rank_1, 202); chk("d_rank2b", push_rank_2, 203);
    @(negedge clk);
    #1; chk("d_done", push_1, 0); chk("d_cnt", grant_count, 64'h0003_0002_0003_0002);

    // Port 2 streams ranks 5,6,7 (base+2) back to back.
    @(negedge clk); set_req(4'b0100, 3);
    #1; chk("e_ready0", req_ready[2], 1); chk("e_latency", push_1, 0);
    @(negedge clk); set_req(4'b0100, 4);
    #1; chk("e_rank5", push_rank_1, 5); chk("e_ready1", req_ready[2], 1); chk("e_push2a", push_2, 0);
    @(negedge clk); set_req(4'b0100, 5);
    #1; chk("e_rank6", push_rank_1, 6); chk("e_ready2", req_ready[2], 1);
    @(negedge clk); req_valid = 4'b0000;
    #1; chk("e_rank7", push_rank_1, 7); chk("e_push1c", push_1, 1);
    @(negedge clk);
    #1; chk("e_done", push_1, 0);

    // Reset while ports 0 and 2 are staged.
    can_push_1 = 1'b0; can_push_2 = 1'b0;
    set_req(4'b0101, 50);
    @(negedge clk); req_valid = 4'b0000; can_push_1 = 1'b1;
    #1; chk("f_live", push_1, 1); chk("f_live_rank", push_rank_1, 50);
    #1; rst = 1'b0;
    #1;
    chk("f_rst_push1", push_1, 0);
    chk("f_rst_push2", push_2, 0);
    chk("f_rst_ready", req_ready, 4'hF);
    chk("f_rst_cnt", grant_count, 0);
    @(negedge clk); rst = 1'b1;
    #1; chk("f_rel_push", push_1, 0);
    @(negedge clk);
    #1; chk("f_after_push", push_1, 0); chk("f_after_rank", push_rank_1, 0);

    // 65535 grants on port 0 reach FFFF, the next one wraps to 0.
    can_push_2 = 1'b0;
    set_req(4'b0001, 0);
    repeat (65535) @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1; chk("g_cnt_ffff", grant_count[0], 16'hFFFF); chk("g_idle", push_1, 0);
    @(negedge clk); set_req(4'b0001, 0);
    @(negedge clk); req_valid = 4'b0000;
    #1; chk("g_push", push_1, 1);
    @(negedge clk);
    #1; chk("g_cnt_wrap", grant_count[0], 16'h0000); chk("g_cnt_all", grant_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/push_arbiter.md
PUSH_ARBITER -- requirements
Module: push_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of push requesters, 2..16.
REQ-002 SHALL have parameter FLOWS, default 10: flow field width, matching the flow scheduler's FLOWS.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  PORTS: per-port push request.
REQ-006 SHALL have port req_rank  input  PORTS x 32: per-port rank.
REQ-007 SHALL have port req_value  input  PORTS x 32: per-port value.
REQ-008 SHALL have port req_flow  input  PORTS x FLOWS: per-port flow.
REQ-009 SHALL have port req_ready  output  PORTS: per-port accept.
REQ-010 SHALL have port can_push_1  input  1: from the scheduler; at least one free slot.
REQ-011 SHALL have port can_push_2  input  1: from the scheduler; at least two free slots.
REQ-012 SHALL have ports push_1, push_rank_1, push_value_1, push_flow_1  output  1/32/32/FLOWS: first push lane to the scheduler.
REQ-013 SHALL have ports push_2, push_rank_2, push_value_2, push_flow_2  output  1/32/32/FLOWS: second push lane to the scheduler.
REQ-014 SHALL have port grant_count  output  PORTS x 16: per-port count of granted pushes.

Function
REQ-015 SHALL hold one staging entry per port (buf_valid, rank, value, flow); transfer occurs when req_valid && req_ready at a rising edge.
REQ-016 SHALL drive req_ready[p] = !buf_valid[p] || grant[p]; the combinational path from can_push_* to req_ready is permitted; sustained throughput is one accept per port per cycle.
REQ-017 SHALL compute grants combinationally from buf_valid, rr_ptr, can_push_1 and can_push_2; there are no grants when can_push_1 = 0.
REQ-018 SHALL scan ports cyclically starting at rr_ptr; the first occupied port goes to lane 1; the second occupied port goes to lane 2 only if can_push_2 = 1.
REQ-019 SHALL drive push_1/push_2 directly from the granted staging entries, in the same cycle as the grant; lane 2 is never asserted without lane 1.
REQ-020 SHALL clear the granted entries' buf_valid at the edge unless the same port reloads them in that cycle.
REQ-021 SHALL advance rr_ptr to (last granted port + 1) mod PORTS after any grant; rr_ptr is unchanged with no grant.
REQ-022 SHALL preserve per-port order: a port's next entry is never pushed before its current one.
REQ-023 SHALL keep push latency at one cycle: an entry accepted at edge t is pushed no earlier than the cycle following t.
REQ-024 SHALL keep push lane outputs at 0 when not asserted, with no X propagation from empty entries.
REQ-025 SHALL increment grant_count[p] once per grant; the counter wraps at 16'hFFFF -> 0.
REQ-026 SHALL treat lanes as rank-agnostic; rank ordering between lanes is the scheduler's responsibility.

Reset
REQ-027 SHALL, on rst low, asynchronously clear all buf_valid, set rr_ptr to 0 and set grant_count to 0; push_1 = push_2 = 0 and req_ready = all-ones while reset is held.
REQ-028 SHALL discard staged entries when reset is asserted mid-operation; no push is emitted on the release edge.

Structure
REQ-029 SHALL use a shared package pifo_pkg holding the push_req_t struct {rank[31:0], value[31:0], flow[FLOWS-1:0]} and the RANK_W = 32 constant.
REQ-030 SHALL place the rotate-and-pick-two logic in one sub-module, rr_pick2 (inputs: occupancy vector, pointer, enable2; outputs: two one-hot grants plus valid bits).

Verification
REQ-031 SHALL check: PORTS = 4, ports 1 and 3 valid, can_push_1 = can_push_2 = 1, rr_ptr = 0 -> lane 1 = port 1, lane 2 = port 3, rr_ptr -> 0, both grant_count = 1.
REQ-032 SHALL check: all 4 ports full, can_push_2 = 0 for 4 cycles -> one push per cycle in order 0, 1, 2, 3; push_2 never high.
REQ-033 SHALL check: can_push_1 = 0 with all ports full -> no push, req_ready = 0000, buffers hold; can_push raised -> ports 0 and 1 pushed in that cycle.
REQ-034 SHALL check: port 2 streams ranks 5, 6, 7 back-to-back alone -> pushed on lane 1 in order 5, 6, 7 over 3 consecutive cycles, req_ready[2] stays high.
REQ-035 SHALL check: reset asserted while ports 0 and 2 are staged -> push_1 = 0 immediately, staged data never emitted, counters = 0.
REQ-036 SHALL check: grant_count[0] preloaded to 16'hFFFF, one grant -> count reads 0.
